line_buffer_ctrl: RTL
=====================

Name: line_buffer_ctrl

Overview:
- Controller that sits directly upstream of single_port_ram and owns its cs/we/addr/din pins.
- Accepts one video line from a valid/ready pixel stream and writes it into the RAM.
- Replays that line REPEAT times on a valid/ready output stream, giving integer vertical upscaling for the LineBuffer scaler path.
- The RAM is single-port with combinational read, so write and replay phases are strictly time-multiplexed.

Parameters:
- ADDR_WIDTH, 6, RAM address width; must match the RAM instance.
- DATA_WIDTH, 30, pixel width (RGB 3x10); must match the RAM instance.
- LINE_WIDTH, 64, pixels per line; must satisfy 1 <= LINE_WIDTH <= 2**ADDR_WIDTH.
- REPEAT, 2, number of output copies of each line; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream pixel valid.
- i_data  input  DATA_WIDTH  upstream pixel.
- o_ready  output  1  block can accept a pixel.
- o_valid  output  1  output pixel valid.
- o_data  output  DATA_WIDTH  output pixel.
- o_eol  output  1  marks the last pixel of each output line; qualified by o_valid.
- o_eof_rep  output  1  marks the last pixel of the last repeat; qualified by o_valid.
- i_ready  input  1  downstream ready.
- o_ram_cs  output  1  RAM chip select.
- o_ram_we  output  1  RAM write enable.
- o_ram_addr  output  ADDR_WIDTH  RAM address.
- o_ram_din  output  DATA_WIDTH  RAM write data.
- i_ram_dout  input  DATA_WIDTH  RAM read data; combinational, valid when cs=1 and we=0.

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- State register with two states: S_WRITE and S_READ. Counters:
  - wr_cnt (ADDR_WIDTH+1 bits)
  - rd_cnt (ADDR_WIDTH+1 bits)
  - rep_cnt ($clog2(REPEAT+1) bits)
- Reset:
  - At a clk edge with reset=1: state=S_WRITE; wr_cnt, rd_cnt, rep_cnt = 0.
  - An in-flight line is discarded; RAM contents are not cleared.
  - After the reset edge: o_ready=1, o_valid=0, o_eol=0, o_eof_rep=0, o_ram_cs=0, o_ram_we=0, o_ram_addr=0, o_ram_din=0.
- All outputs are combinational decodes of the registered state plus the handshake inputs. There are no extra pipeline registers.
- S_WRITE:
  - o_ready=1, o_valid=0.
  - On i_valid=1: o_ram_cs=1, o_ram_we=1, o_ram_addr=wr_cnt, o_ram_din=i_data. The pixel is written at that clk edge and wr_cnt increments.
  - On i_valid=0: cs=0, we=0, addr=wr_cnt, din=0.
  - When a write accepts with wr_cnt==LINE_WIDTH-1: wr_cnt<=0, rd_cnt<=0, rep_cnt<=0, state<=S_READ.
- S_READ:
  - o_ready=0, o_valid=1.
  - o_ram_cs=1, o_ram_we=0, o_ram_addr=rd_cnt, o_data=i_ram_dout (same cycle, zero latency).
  - o_data is 0 in S_WRITE.
  - o_eol = (rd_cnt==LINE_WIDTH-1).
  - o_eof_rep = o_eol && (rep_cnt==REPEAT-1).
  - Transfer occurs when o_valid && i_ready; rd_cnt increments.
  - Transfer with o_eol=1: rd_cnt<=0 and rep_cnt increments. If rep_cnt==REPEAT-1, instead state<=S_WRITE and rep_cnt<=0.
- Backpressure: with i_ready=0, o_data, o_ram_addr and the counters hold, and o_valid stays 1. Once asserted, o_valid never drops before its transfer completes.
- Input stall: with i_valid=0 in S_WRITE, no write occurs and wr_cnt holds.
- Latency: the first output pixel is valid in the cycle after the edge that writes the last input pixel.
- Throughput: LINE_WIDTH input cycles plus REPEAT*LINE_WIDTH output cycles per line, at best.
- The RAM never sees cs=1 with an address >= LINE_WIDTH.
- Boundaries:
  - LINE_WIDTH=1: every accept flips state immediately; o_eol=1 on every output pixel.
  - REPEAT=1: pure line-delay, one pass per line.
  - Simultaneous i_valid in S_READ is ignored (o_ready=0).
  - Reset asserted mid-read aborts the replay; the next output only follows a fresh complete line.

Decomposition:
- Package line_buffer_pkg holds:
  - typedef enum logic {S_WRITE, S_READ} lb_state_e
  - default constants LB_ADDR_WIDTH=6, LB_DATA_WIDTH=30
  - a typedef for the pixel word (logic [LB_DATA_WIDTH-1:0])
- No sub-module inside the controller.
- A thin top line_buffer wires line_buffer_ctrl to single_port_ram. The bench instantiates both through that top.

Test Plan (LINE_WIDTH=4, REPEAT=2, ADDR_WIDTH=6, DATA_WIDTH=30):
- Reset, then stream 1,2,3,4 with continuous i_valid and i_ready=1 -> RAM writes at addr 0..3. Outputs 1,2,3,4,1,2,3,4 in consecutive cycles, o_eol on both 4s, o_eof_rep on the second 4 only, o_ready back to 1 next cycle.
- Drop i_valid for 3 cycles between pixels 2 and 3 -> no RAM write during the gap. The replay still equals 1,2,3,4 twice.
- During replay, hold i_ready=0 for 5 cycles at rd_cnt=2 -> o_data holds 3 and o_valid holds 1. Sequence unchanged; total output cycles = 8+5.
- Assert i_valid with data 9 during S_READ -> o_ready=0, no write, RAM addr stays a read address. The next line's first written value is whatever is presented after return to S_WRITE.
- Assert reset for 1 cycle at replay pixel 2 of repeat 0 -> o_valid=0 after the edge and o_ready=1. Next line 5,6,7,8 replays as 5,6,7,8,5,6,7,8.
- Parameter sweep (LINE_WIDTH=1, REPEAT=1) with input A,B -> output A,B. o_eol and o_eof_rep are asserted on every output pixel.

Source files
------------

// File: rtl/line_buffer_pkg.sv
// Shared types and default widths for the line buffer controller and its RAM.
package line_buffer_pkg;
  typedef enum logic {S_WRITE, S_READ} lb_state_e;

  localparam int LB_ADDR_WIDTH = 6;
  localparam int LB_DATA_WIDTH = 30;

  typedef logic [LB_DATA_WIDTH-1:0] pixel_t;
endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Pixel stream in/out plus the RAM pin bundle owned by the line buffer controller.
interface line_buffer_ctrl_if
  import line_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
  parameter int DATA_WIDTH = LB_DATA_WIDTH
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_ready;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_eol;
  logic                  o_eof_rep;
  logic                  i_ready;
  logic                  o_ram_cs;
  logic                  o_ram_we;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic [DATA_WIDTH-1:0] o_ram_din;
  logic [DATA_WIDTH-1:0] i_ram_dout;

  // Controller side.
  modport master (
    input  i_valid, i_data, i_ready, i_ram_dout,
    output o_ready, o_valid, o_data, o_eol, o_eof_rep,
    output o_ram_cs, o_ram_we, o_ram_addr, o_ram_din
  );

  // Upstream source, downstream sink and RAM side.
  modport slave (
    output i_valid, i_data, i_ready, i_ram_dout,
    input  o_ready, o_valid, o_data, o_eol, o_eof_rep,
    input  o_ram_cs, o_ram_we, o_ram_addr, o_ram_din
  );
endinterface

// File: rtl/single_port_ram.sv
// Single-port RAM: synchronous write, combinational read when selected and not writing.
module single_port_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  cs_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (cs_i && we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  assign dout_o = (cs_i && !we_i) ? mem_q[addr_i] : '0;
endmodule

// File: rtl/line_buffer_ctrl.sv
// Writes one line into a single-port RAM, then replays it REPEAT times.
// Outputs are pure decodes of state/counters and handshake inputs; read data is zero latency.
module line_buffer_ctrl
  import line_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
  parameter int DATA_WIDTH = LB_DATA_WIDTH,
  parameter int LINE_WIDTH = 64,
  parameter int REPEAT     = 2
) (
  input  logic              clk,
  input  logic              reset,
  line_buffer_ctrl_if.master bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int RW = $clog2(REPEAT + 1);
  localparam logic [CW-1:0] LAST_PIX = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] LAST_REP = RW'(REPEAT - 1);

  lb_state_e         state_q, state_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [RW-1:0]     rep_cnt_q, rep_cnt_d;

  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    rep_cnt_d      = rep_cnt_q;
    bus.o_ready    = 1'b0;
    bus.o_valid    = 1'b0;
    bus.o_data     = '0;
    bus.o_eol      = 1'b0;
    bus.o_eof_rep  = 1'b0;
    bus.o_ram_cs   = 1'b0;
    bus.o_ram_we   = 1'b0;
    bus.o_ram_addr = wr_cnt_q[ADDR_WIDTH-1:0];
    bus.o_ram_din  = '0;

    case (state_q)
      S_WRITE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) begin
          bus.o_ram_cs  = 1'b1;
          bus.o_ram_we  = 1'b1;
          bus.o_ram_din = bus.i_data;
          if (wr_cnt_q == LAST_PIX) begin
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            rep_cnt_d = '0;
            state_d   = S_READ;
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end

      S_READ: begin
        bus.o_valid    = 1'b1;
        bus.o_ram_cs   = 1'b1;
        bus.o_ram_addr = rd_cnt_q[ADDR_WIDTH-1:0];
        bus.o_data     = bus.i_ram_dout;
        bus.o_eol      = (rd_cnt_q == LAST_PIX);
        bus.o_eof_rep  = (rd_cnt_q == LAST_PIX) && (rep_cnt_q == LAST_REP);
        // Counters only move on a completed transfer, so backpressure holds address and data.
        if (bus.i_ready) begin
          if (rd_cnt_q == LAST_PIX) begin
            rd_cnt_d = '0;
            if (rep_cnt_q == LAST_REP) begin
              rep_cnt_d = '0;
              state_d   = S_WRITE;
            end else begin
              rep_cnt_d = rep_cnt_q + RW'(1);
            end
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end
      end

      default: state_d = S_WRITE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_WRITE;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end
endmodule
